// File: rtl/fifo_rr_drain_if.sv
// Bundle of fifo-side and consumer-side signals for the round-robin drain scheduler.
interface fifo_rr_drain_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SRC_WIDTH  = 2
);
  logic [NUM_SRC-1:0]            i_empty;
  logic [NUM_SRC*DATA_WIDTH-1:0] i_data;
  logic [NUM_SRC-1:0]            i_enable;
  logic [NUM_SRC-1:0]            o_pop;
  logic                          o_valid;
  logic [DATA_WIDTH-1:0]         o_data;
  logic [SRC_WIDTH-1:0]          o_src;
  logic                          i_ready;

  modport slave (
    input  i_empty, i_data, i_enable, i_ready,
    output o_pop, o_valid, o_data, o_src
  );

  modport master (
    output i_empty, i_data, i_enable, i_ready,
    input  o_pop, o_valid, o_data, o_src
  );
endinterface

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_SRC fifos onto one registered valid/ready stream,
// with a grant held for up to BURST_LEN consecutive words.
//   state | meaning
//   IDLE  | no owner; scan starts at rr_ptr
//   SERVE | owner holds grant; burst_cnt words taken in current burst
module fifo_rr_drain #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fifo_rr_drain_if.slave bus
);
  localparam int SRC_WIDTH = $clog2(NUM_SRC);
  localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t                 state_q, state_d;
  logic [SRC_WIDTH-1:0]   owner_q, owner_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [SRC_WIDTH-1:0]   rr_q, rr_d;
  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [SRC_WIDTH-1:0]   src_q, src_d;

  logic [NUM_SRC-1:0]     eligible;
  logic [NUM_SRC-1:0]     pop;
  logic                   load;
  logic                   keep;
  logic                   found;
  logic [SRC_WIDTH-1:0]   pick;
  logic [SRC_WIDTH-1:0]   idx;

  function automatic logic [SRC_WIDTH-1:0] inc_mod(input logic [SRC_WIDTH-1:0] v);
    if (int'(v) == NUM_SRC - 1) return '0;
    return v + SRC_WIDTH'(1);
  endfunction

  always_comb begin
    eligible = ~bus.i_empty & bus.i_enable;
    load     = !valid_q || bus.i_ready;
    keep     = (state_q == SERVE) && eligible[owner_q] && (cnt_q < CNT_WIDTH'(BURST_LEN));
    found    = 1'b0;
    pick     = '0;
    // On rotation the scan starts just past the owner so it gets lowest priority.
    idx      = (state_q == SERVE) ? inc_mod(owner_q) : rr_q;
    if (keep) begin
      found = 1'b1;
      pick  = owner_q;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!found && eligible[idx]) begin
          found = 1'b1;
          pick  = idx;
        end
        idx = inc_mod(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    pop     = '0;
    if (load) begin
      if (found) begin
        pop[pick] = 1'b1;
        valid_d   = 1'b1;
        data_d    = bus.i_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
        src_d     = pick;
        state_d   = SERVE;
        if (keep) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
          // A rotation that lands back on the owner starts a fresh burst.
          owner_d = pick;
          cnt_d   = CNT_WIDTH'(1);
          if (state_q == SERVE) rr_d = inc_mod(owner_q);
        end
      end else begin
        valid_d = 1'b0;
        if (state_q == SERVE) begin
          state_d = IDLE;
          rr_d    = inc_mod(owner_q);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign bus.o_pop   = i_rst ? '0 : pop;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_src   = src_q;
endmodule
